port_tx_fsm: RTL and testbench

Egress-side controller for one output port of the simple switch. It drains packets that the ingress FSM wrote into the port FIFO and presents them byte by byte on the port output with a valid/ready handshake. It checks the trailing parity byte and aborts a packet if the consumer stalls too long. It drives `port_busy` back toward the ingress side while a packet is in flight.

---
 rtl/port_tx_fsm_pkg.sv | 21 ++
 rtl/port_tx_fsm_tx_watchdog.sv | 37 +++
 rtl/port_tx_fsm.sv | 174 +++++++++++++++++
 tb/tb_port_tx_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_tx_fsm_pkg.sv
// Shared switch-wide definitions for the port datapath.
// - tx_state_e : state encoding of the egress port FSM.
// - eop_bit()  : position of the end-of-packet flag in a FIFO entry. The
//                flag sits directly above the data byte, so ingress and
//                egress agree on it for any data width.
package port_tx_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_FLUSH = 3'd5
    } tx_state_e;

    function automatic int unsigned eop_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/port_tx_fsm_tx_watchdog.sv
// Stall watchdog for the egress port. Counts stalled cycles and flags
// expiry once TO_CYCLES-1 stalls have been seen, so the TO_CYCLES-th
// consecutive stalled cycle is the one on which the owner acts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count one stalled cycle
//   clr        : restart the count (has priority over en)
//   expired    : count has reached TO_CYCLES-1
module tx_watchdog #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = $clog2(TO_CYCLES);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TO_CYCLES - 1));

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/port_tx_fsm.sv
// Egress controller for one switch output port. Pops packets from the port
// FIFO and presents them byte by byte on a valid/ready interface, checks
// the trailing parity byte, and aborts a packet whose consumer stalls for
// too long (the rest of that packet is then drained from the FIFO).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   fifo_empty  : port FIFO has no entries
//   fifo_data   : FIFO read data {eop, byte}, valid the cycle after a pop
//   fifo_rd_en  : pop one FIFO entry (combinational)
//   port_ready  : consumer accepts the current byte
//   port_valid  : port_data/port_last are valid
//   port_data   : output byte (address, payload..., parity)
//   port_last   : marks the parity byte
//   port_busy   : a packet is in flight (combinational, state != IDLE)
//   parity_err  : one-cycle pulse, received parity differs from XOR of bytes
//   tx_abort    : one-cycle pulse, packet dropped by the stall watchdog
//   pkt_cnt     : packets completed without abort (wraps)
module port_tx_fsm
    import port_tx_fsm_pkg::*;
#(
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned TO_CYCLES = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [W_WIDTH:0]     fifo_data,
    output logic                 fifo_rd_en,
    input  logic                 port_ready,
    output logic                 port_valid,
    output logic [W_WIDTH-1:0]   port_data,
    output logic                 port_last,
    output logic                 port_busy,
    output logic                 parity_err,
    output logic                 tx_abort,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    localparam int unsigned EOP = eop_bit(W_WIDTH);

    tx_state_e            state, state_d;
    logic [W_WIDTH-1:0]   acc, acc_d;
    logic                 rd_q;           // a pop was issued last cycle
    logic                 valid_d, last_d, perr_d, abort_d;
    logic [W_WIDTH-1:0]   data_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic wd_en, wd_clr, wd_expired;

    assign port_busy = (state != ST_IDLE);
    assign wd_en     = (state == ST_SEND) && !port_ready;
    assign wd_clr    = (state == ST_FETCH);

    tx_watchdog #(
        .TO_CYCLES (TO_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            port_valid <= 1'b0;
            port_data  <= '0;
            port_last  <= 1'b0;
            parity_err <= 1'b0;
            tx_abort   <= 1'b0;
            pkt_cnt    <= '0;
            acc        <= '0;
            rd_q       <= 1'b0;
        end else begin
            state      <= state_d;
            port_valid <= valid_d;
            port_data  <= data_d;
            port_last  <= last_d;
            parity_err <= perr_d;
            tx_abort   <= abort_d;
            pkt_cnt    <= cnt_d;
            acc        <= acc_d;
            rd_q       <= fifo_rd_en;
        end
    end

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        state_d    = state;
        valid_d    = port_valid;
        data_d     = port_data;
        last_d     = port_last;
        perr_d     = 1'b0;
        abort_d    = 1'b0;
        cnt_d      = pkt_cnt;
        acc_d      = acc;
        fifo_rd_en = 1'b0;

        unique case (state)
            ST_IDLE: begin
                acc_d = '0;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            // Entry popped last cycle is on fifo_data now.
            ST_FETCH: begin
                data_d  = fifo_data[W_WIDTH-1:0];
                last_d  = fifo_data[EOP];
                valid_d = 1'b1;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (port_ready) begin
                    // Accept wins over a watchdog expiring in the same cycle.
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (!port_last) begin
                        acc_d = acc ^ port_data;
                        if (!fifo_empty) begin
                            fifo_rd_en = 1'b1;
                            state_d    = ST_FETCH;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        perr_d  = (acc != port_data);
                        cnt_d   = pkt_cnt + 1'b1;
                        state_d = ST_GAP;
                    end
                end else if (wd_expired) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    abort_d = 1'b1;
                    // If the held byte was the EOP entry nothing is left to drain.
                    state_d = port_last ? ST_GAP : ST_FLUSH;
                end
            end

            ST_WAIT: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            // Drain the aborted packet up to and including its EOP entry;
            // stop popping once that entry has arrived.
            ST_FLUSH: begin
                if (rd_q && fifo_data[EOP]) begin
                    state_d = ST_GAP;
                end else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_port_tx_fsm.sv
// Directed bench for port_tx_fsm. Instance 0 uses the default 16-cycle
// watchdog, instance 1 a 4-cycle watchdog for the abort cases. Each
// instance has its own FIFO model and a monitor that logs accepted bytes
// and pulse counts. Inputs change at negedge+1, checks run at negedge+1,
// the monitor samples at negedge+2.
module tb_port_tx_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance 0 (TO_CYCLES = 16) ----------------
    logic        fifo_empty_0, fifo_rd_en_0, port_valid_0, port_last_0;
    logic        port_busy_0, parity_err_0, tx_abort_0;
    logic        port_ready_0 = 1'b0;
    logic [8:0]  fifo_data_0  = '0;
    logic [7:0]  port_data_0;
    logic [15:0] pkt_cnt_0;
    logic [8:0]  mem_0 [64];
    logic [5:0]  wr_0 = '0;
    logic [5:0]  rd_0 = '0;

    port_tx_fsm #(.W_WIDTH(8), .TO_CYCLES(16), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_0), .fifo_data(fifo_data_0),
        .fifo_rd_en(fifo_rd_en_0), .port_ready(port_ready_0), .port_valid(port_valid_0),
        .port_data(port_data_0), .port_last(port_last_0), .port_busy(port_busy_0),
        .parity_err(parity_err_0), .tx_abort(tx_abort_0), .pkt_cnt(pkt_cnt_0)
    );

    assign fifo_empty_0 = (wr_0 == rd_0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_0 <= wr_0;
        else if (fifo_rd_en_0) begin
            fifo_data_0 <= mem_0[rd_0];
            rd_0        <= rd_0 + 1'b1;
        end
    end

    logic [8:0] seen_0[$];
    int perr_n0 = 0, abort_n0 = 0;
    always begin
        @(negedge clk); #2;
        if (port_valid_0 && port_ready_0) seen_0.push_back({port_last_0, port_data_0});
        if (parity_err_0) perr_n0++;
        if (tx_abort_0) abort_n0++;
    end

    // ---------------- instance 1 (TO_CYCLES = 4) ----------------
    logic        fifo_empty_1, fifo_rd_en_1, port_valid_1, port_last_1;
    logic        port_busy_1, parity_err_1, tx_abort_1;
    logic        port_ready_1 = 1'b0;
    logic [8:0]  fifo_data_1  = '0;
    logic [7:0]  port_data_1;
    logic [15:0] pkt_cnt_1;
    logic [8:0]  mem_1 [64];
    logic [5:0]  wr_1 = '0;
    logic [5:0]  rd_1 = '0;

    port_tx_fsm #(.W_WIDTH(8), .TO_CYCLES(4), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_1), .fifo_data(fifo_data_1),
        .fifo_rd_en(fifo_rd_en_1), .port_ready(port_ready_1), .port_valid(port_valid_1),
        .port_data(port_data_1), .port_last(port_last_1), .port_busy(port_busy_1),
        .parity_err(parity_err_1), .tx_abort(tx_abort_1), .pkt_cnt(pkt_cnt_1)
    );

    assign fifo_empty_1 = (wr_1 == rd_1);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_1 <= wr_1;
        else if (fifo_rd_en_1) begin
            fifo_data_1 <= mem_1[rd_1];
            rd_1        <= rd_1 + 1'b1;
        end
    end

    logic [8:0] seen_1[$];
    int perr_n1 = 0, abort_n1 = 0;
    always begin
        @(negedge clk); #2;
        if (port_valid_1 && port_ready_1) seen_1.push_back({port_last_1, port_data_1});
        if (parity_err_1) perr_n1++;
        if (tx_abort_1) abort_n1++;
    end

    // ---------------- helpers ----------------
    typedef struct packed {
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        busy;
        logic        perr;
        logic        abort;
        logic        rd_en;
        logic [15:0] cnt;
    } obs_t;

    function automatic obs_t obs(input int i);
        obs_t o;
        if (i == 0) o = '{port_valid_0, port_data_0, port_last_0, port_busy_0,
                          parity_err_0, tx_abort_0, fifo_rd_en_0, pkt_cnt_0};
        else        o = '{port_valid_1, port_data_1, port_last_1, port_busy_1,
                          parity_err_1, tx_abort_1, fifo_rd_en_1, pkt_cnt_1};
        return o;
    endfunction

    function automatic logic [8:0] seen(input int i, input int k);
        return (i == 0) ? seen_0[k] : seen_1[k];
    endfunction

    function automatic int seen_n(input int i);
        return (i == 0) ? seen_0.size() : seen_1.size();
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic push(input int i, input logic [8:0] d);
        if (i == 0) begin mem_0[wr_0] = d; wr_0 = wr_0 + 1'b1; end
        else        begin mem_1[wr_1] = d; wr_1 = wr_1 + 1'b1; end
    endtask

    task automatic set_ready(input int i, input logic v);
        if (i == 0) port_ready_0 = v;
        else        port_ready_1 = v;
    endtask

    task automatic push_pkt(input int i, input logic [7:0] b0, b1, b2, p);
        push(i, {1'b0, b0});
        push(i, {1'b0, b1});
        push(i, {1'b0, b2});
        push(i, {1'b1, p});
    endtask

    task automatic wait_idle(input int i, input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (!obs(i).busy) done = 1'b1;
        end
        check({tag, " returns to idle"}, 32'(done), 32'd1);
    endtask

    // Check the accepted-byte log of instance i from index base against a packet.
    task automatic check_log(input int i, input int base, input string tag,
                             input logic [7:0] b0, b1, b2, p);
        logic [7:0] b [4];
        b = '{b0, b1, b2, p};
        check({tag, " byte count"}, 32'(seen_n(i) - base), 32'd4);
        if (seen_n(i) - base == 4)
            for (int k = 0; k < 4; k++)
                check({tag, " byte"}, 32'(seen(i, base + k)), {23'd0, (k == 3), b[k]});
    endtask

    // Full packet with port_ready held high, checked cycle by cycle.
    task automatic send_checked(input int i, input string tag,
                                input logic [7:0] b0, b1, b2, p,
                                input logic exp_perr, input logic [15:0] exp_cnt);
        logic [7:0] b [4];
        obs_t o;
        b = '{b0, b1, b2, p};
        push_pkt(i, b0, b1, b2, p);
        for (int k = 0; k < 4; k++) begin
            tick(); o = obs(i);
            check({tag, " fetch valid"}, 32'(o.valid), 32'd0);
            check({tag, " fetch busy"},  32'(o.busy),  32'd1);
            tick(); o = obs(i);
            check({tag, " send valid"}, 32'(o.valid), 32'd1);
            check({tag, " send data"},  32'(o.data),  32'(b[k]));
            check({tag, " send last"},  32'(o.last),  32'(k == 3));
        end
        tick(); o = obs(i);
        check({tag, " gap valid"},  32'(o.valid), 32'd0);
        check({tag, " gap busy"},   32'(o.busy),  32'd1);
        check({tag, " parity_err"}, 32'(o.perr),  32'(exp_perr));
        check({tag, " pkt_cnt"},    32'(o.cnt),   32'(exp_cnt));
        tick(); o = obs(i);
        check({tag, " parity_err after pulse"}, 32'(o.perr), 32'd0);
        check({tag, " idle busy"},              32'(o.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        obs_t o;
        int base, ab, pe;

        // ---- reset state ----
        repeat (2) tick();
        o = obs(0);
        check("reset valid", 32'(o.valid), 32'd0);
        check("reset data",  32'(o.data),  32'd0);
        check("reset busy",  32'(o.busy),  32'd0);
        check("reset cnt",   32'(o.cnt),   32'd0);
        rst_n = 1'b1;
        tick();
        o = obs(0);
        check("idle rd_en empty fifo", 32'(o.rd_en), 32'd0);
        check("idle last",  32'(o.last),  32'd0);
        check("idle perr",  32'(o.perr),  32'd0);
        check("idle abort", 32'(o.abort), 32'd0);
        check("idle cnt1",  32'(obs(1).cnt), 32'd0);

        // ---- basic packet, good parity ----
        set_ready(0, 1'b1);
        send_checked(0, "basic", 8'h05, 8'h11, 8'h22, 8'h36, 1'b0, 16'd1);

        // ---- parity error ----
        pe = perr_n0;
        send_checked(0, "parity", 8'h05, 8'h11, 8'h22, 8'h37, 1'b1, 16'd2);
        check("parity pulse count", 32'(perr_n0 - pe), 32'd1);

        // ---- backpressure: 5 stalls on 0x11, watchdog 16 ----
        base = seen_n(0); ab = abort_n0;
        push_pkt(0, 8'h05, 8'h11, 8'h22, 8'h36);
        tick(); tick(); tick();          // FETCH, SEND 0x05, FETCH
        set_ready(0, 1'b0);
        tick();
        check("bp first data", 32'(obs(0).data), 32'h11);
        for (int s = 0; s < 5; s++) begin
            tick(); o = obs(0);
            check("bp held data",  32'(o.data),  32'h11);
            check("bp held valid", 32'(o.valid), 32'd1);
            check("bp no abort",   32'(o.abort), 32'd0);
        end
        set_ready(0, 1'b1);
        wait_idle(0, "bp");
        check_log(0, base, "bp", 8'h05, 8'h11, 8'h22, 8'h36);
        check("bp abort count", 32'(abort_n0 - ab), 32'd0);
        check("bp pkt_cnt", 32'(obs(0).cnt), 32'd3);

        // ---- starvation: FIFO empties after 0x11 ----
        base = seen_n(0); ab = abort_n0; pe = perr_n0;
        push(0, 9'h005);
        push(0, 9'h011);
        tick(); tick(); tick(); tick();  // FETCH, SEND, FETCH, SEND 0x11
        check("starve data", 32'(obs(0).data), 32'h11);
        for (int s = 0; s < 4; s++) begin
            tick(); o = obs(0);
            check("starve valid", 32'(o.valid), 32'd0);
            check("starve busy",  32'(o.busy),  32'd1);
            check("starve rd_en", 32'(o.rd_en), 32'd0);
        end
        push(0, 9'h022);
        push(0, 9'h136);
        wait_idle(0, "starve");
        check_log(0, base, "starve", 8'h05, 8'h11, 8'h22, 8'h36);
        check("starve abort count", 32'(abort_n0 - ab), 32'd0);
        check("starve perr count",  32'(perr_n0 - pe),  32'd0);
        check("starve pkt_cnt", 32'(obs(0).cnt), 32'd4);

        // ---- abort: watchdog 4, stall on 0x11 ----
        base = seen_n(1); ab = abort_n1;
        set_ready(1, 1'b1);
        push_pkt(1, 8'h05, 8'h11, 8'h22, 8'h36);
        tick(); tick(); tick();
        set_ready(1, 1'b0);
        tick();
        check("abort held data", 32'(obs(1).data), 32'h11);
        for (int s = 0; s < 3; s++) begin
            tick(); o = obs(1);
            check("abort not yet", 32'(o.abort), 32'd0);
            check("abort valid held", 32'(o.valid), 32'd1);
        end
        tick(); o = obs(1);
        check("abort pulse",  32'(o.abort), 32'd1);
        check("abort valid",  32'(o.valid), 32'd0);
        check("abort busy",   32'(o.busy),  32'd1);
        tick();
        check("abort pulse width", 32'(obs(1).abort), 32'd0);
        wait_idle(1, "abort");
        check("abort fifo drained", 32'(fifo_empty_1), 32'd1);
        check("abort pkt_cnt",      32'(obs(1).cnt), 32'd0);
        check("abort bytes out",    32'(seen_n(1) - base), 32'd1);
        check("abort count",        32'(abort_n1 - ab), 32'd1);

        // ---- accept on the limit cycle wins over abort ----
        base = seen_n(1); ab = abort_n1;
        set_ready(1, 1'b1);
        push_pkt(1, 8'h05, 8'h11, 8'h22, 8'h36);
        tick(); tick(); tick();
        set_ready(1, 1'b0);
        tick();
        for (int s = 0; s < 3; s++) begin
            tick();
            check("limit held data", 32'(obs(1).data), 32'h11);
        end
        set_ready(1, 1'b1);
        tick();
        check("limit no abort", 32'(obs(1).abort), 32'd0);
        wait_idle(1, "limit");
        check_log(1, base, "limit", 8'h05, 8'h11, 8'h22, 8'h36);
        check("limit abort count", 32'(abort_n1 - ab), 32'd0);
        check("limit pkt_cnt", 32'(obs(1).cnt), 32'd1);

        // ---- reset in the middle of SEND ----
        set_ready(0, 1'b0);
        push_pkt(0, 8'h05, 8'h11, 8'h22, 8'h36);
        tick(); tick();
        check("pre-reset valid", 32'(obs(0).valid), 32'd1);
        rst_n = 1'b0;
        #1;
        o = obs(0);
        check("async reset valid", 32'(o.valid), 32'd0);
        check("async reset data",  32'(o.data),  32'd0);
        check("async reset last",  32'(o.last),  32'd0);
        check("async reset busy",  32'(o.busy),  32'd0);
        check("async reset rd_en", 32'(o.rd_en), 32'd0);
        check("async reset cnt",   32'(o.cnt),   32'd0);
        check("async reset cnt1",  32'(obs(1).cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        set_ready(0, 1'b1);
        send_checked(0, "post-reset", 8'hA0, 8'h0B, 8'hC0, 8'h6B, 1'b0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
